// File: rtl/memory_entry_controller.sv
// Key-value cache controller: holds keys/valid bits, does associative lookup and
// free-slot allocation, and sequences one-hot strobes into an external value bank.
module memory_entry_controller #(
  parameter int NUM_ENTRIES = 8,
  parameter int KEY_WIDTH   = 16,
  parameter int VALUE_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               op_valid,
  output logic                               op_ready,
  input  logic [1:0]                         op_code,
  input  logic [KEY_WIDTH-1:0]               op_key,
  input  logic [VALUE_WIDTH-1:0]             op_value,
  output logic                               resp_valid,
  input  logic                               resp_ready,
  output logic [1:0]                         resp_status,
  output logic [VALUE_WIDTH-1:0]             resp_value,
  output logic [NUM_ENTRIES-1:0]             entry_write,
  output logic [NUM_ENTRIES-1:0]             entry_select,
  output logic [VALUE_WIDTH-1:0]             entry_data_in,
  input  logic [VALUE_WIDTH-1:0]             entry_data_out,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int OCC_W = $clog2(NUM_ENTRIES + 1);

  localparam logic [1:0] OP_GET = 2'b00;
  localparam logic [1:0] OP_PUT = 2'b01;
  localparam logic [1:0] OP_DEL = 2'b10;

  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_MISS   = 2'b01;
  localparam logic [1:0] ST_FULL   = 2'b10;
  localparam logic [1:0] ST_BAD_OP = 2'b11;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITE, READ, RESP} state_t;

  state_t                  state_reg;
  logic [1:0]              code_reg;
  logic [KEY_WIDTH-1:0]    key_reg;
  logic [VALUE_WIDTH-1:0]  value_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic                    new_alloc_reg;
  logic [KEY_WIDTH-1:0]    keys_reg [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]  valid_reg;

  logic [NUM_ENTRIES-1:0]  match_vec;
  logic [NUM_ENTRIES-1:0]  free_vec;
  logic                    hit;
  logic                    has_free;
  logic [IDX_W-1:0]        hit_idx;
  logic [IDX_W-1:0]        free_idx;

  generate
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_cmp
      assign match_vec[gi] = valid_reg[gi] && (keys_reg[gi] == key_reg);
      assign free_vec[gi]  = !valid_reg[gi];
    end
  endgenerate

  // Descending scan so the lowest matching / free index wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (free_vec[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  function automatic logic [NUM_ENTRIES-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      valid_reg     <= '0;
      occupancy     <= '0;
      op_ready      <= 1'b1;
      resp_valid    <= 1'b0;
      resp_status   <= ST_OK;
      resp_value    <= '0;
      entry_write   <= '0;
      entry_select  <= '0;
      entry_data_in <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (op_valid && op_ready) begin
            code_reg   <= op_code;
            key_reg    <= op_key;
            value_reg  <= op_value;
            resp_value <= '0;
            op_ready   <= 1'b0;
            state_reg  <= LOOKUP;
          end
        end
        LOOKUP: begin
          case (code_reg)
            OP_GET: begin
              if (hit) begin
                idx_reg      <= hit_idx;
                entry_select <= onehot(hit_idx);
                state_reg    <= READ;
              end else begin
                resp_status <= ST_MISS;
                resp_valid  <= 1'b1;
                state_reg   <= RESP;
              end
            end
            OP_PUT: begin
              if (hit || has_free) begin
                idx_reg       <= hit ? hit_idx : free_idx;
                new_alloc_reg <= !hit;
                entry_write   <= onehot(hit ? hit_idx : free_idx);
                entry_data_in <= value_reg;
                state_reg     <= WRITE;
              end else begin
                resp_status <= ST_FULL;
                resp_valid  <= 1'b1;
                state_reg   <= RESP;
              end
            end
            OP_DEL: begin
              // Only the valid bit is dropped; the stored value is left untouched.
              if (hit) begin
                valid_reg[hit_idx] <= 1'b0;
                if (occupancy != '0)
                  occupancy <= occupancy - OCC_W'(1);
                resp_status <= ST_OK;
              end else begin
                resp_status <= ST_MISS;
              end
              resp_valid <= 1'b1;
              state_reg  <= RESP;
            end
            default: begin
              resp_status <= ST_BAD_OP;
              resp_valid  <= 1'b1;
              state_reg   <= RESP;
            end
          endcase
        end
        WRITE: begin
          keys_reg[idx_reg]  <= key_reg;
          valid_reg[idx_reg] <= 1'b1;
          if (new_alloc_reg && (occupancy != OCC_W'(NUM_ENTRIES)))
            occupancy <= occupancy + OCC_W'(1);
          entry_write   <= '0;
          entry_data_in <= '0;
          resp_status   <= ST_OK;
          resp_valid    <= 1'b1;
          state_reg     <= RESP;
        end
        READ: begin
          resp_value   <= entry_data_out;
          entry_select <= '0;
          resp_status  <= ST_OK;
          resp_valid   <= 1'b1;
          state_reg    <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            op_ready   <= 1'b1;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/memory_entry_controller.md
Name: memory_entry_controller

Overview:
- Sequences a bank of NUM_ENTRIES value-storage registers for the key-value cache.
- Each storage entry has a per-entry write strobe, a per-entry select strobe and a shared tri-state read bus. Unselected entries float their outputs.
- The controller holds keys and valid bits internally, accepts GET/PUT/DEL commands over a valid/ready handshake, and performs associative lookup and free-slot allocation.
- It drives exactly one entry strobe at a time and returns a response over a second valid/ready handshake.

Parameters:
- NUM_ENTRIES, 8, number of storage entries; must be ≥2.
- KEY_WIDTH, 16, key width in bits.
- VALUE_WIDTH, 32, value width in bits; matches the storage entry LENGTH.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- op_valid  input  1  command present.
- op_ready  output  1  controller can accept a command.
- op_code  input  2  command: 00 GET, 01 PUT, 10 DEL, 11 reserved.
- op_key  input  KEY_WIDTH  command key.
- op_value  input  VALUE_WIDTH  PUT data.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_status  output  2  00 OK, 01 MISS, 10 FULL, 11 BAD_OP.
- resp_value  output  VALUE_WIDTH  GET data; 0 unless GET hit.
- entry_write  output  NUM_ENTRIES  one-hot-or-zero write strobe per entry.
- entry_select  output  NUM_ENTRIES  one-hot-or-zero read select per entry.
- entry_data_in  output  VALUE_WIDTH  shared write data to all entries.
- entry_data_out  input  VALUE_WIDTH  shared read bus; high-Z when no entry is selected.
- occupancy  output  $clog2(NUM_ENTRIES+1)  count of valid entries.

Behaviour:
- Reset values: state IDLE, all valid bits 0, occupancy 0, op_ready 1, resp_valid 0, resp_status 00, resp_value 0, entry_write 0, entry_select 0, entry_data_in 0.
- Keys are not cleared on reset; they are don't-care while invalid.
- Reset asserted in any state aborts the operation. No strobe is issued in the following cycle, and any pending response is dropped.
- IDLE:
  - op_ready = 1.
  - When op_valid && op_ready, latch op_code, op_key and op_value, then go to LOOKUP.
  - op_ready is 0 in every other state.
- LOOKUP (1 cycle): compare the latched key against all valid entries.
  - hit_idx = lowest-index valid match.
  - free_idx = lowest-index invalid entry.
  - Outcomes:
    - GET hit → READ.
    - GET miss → RESP with MISS.
    - PUT hit → WRITE at hit_idx (overwrite in place; occupancy unchanged).
    - PUT miss with a free entry → WRITE at free_idx.
    - PUT miss with no free entry → RESP with FULL; no state change.
    - DEL hit → clear valid[hit_idx], decrement occupancy, RESP with OK; the storage entry is not written.
    - DEL miss → RESP with MISS.
    - op_code 11 → RESP with BAD_OP.
- WRITE (1 cycle):
  - entry_write[idx] = 1 and entry_data_in = latched value.
  - On the same edge: key[idx] ← latched key and valid[idx] ← 1. Occupancy increments only on a new allocation.
  - Next state RESP with OK.
- READ (1 cycle):
  - entry_select[idx] = 1.
  - resp_value ← entry_data_out, sampled at the end of this cycle.
  - Next state RESP with OK.
- RESP:
  - resp_valid = 1; status and value are held stable until resp_ready.
  - On resp_valid && resp_ready, go to IDLE; resp_value clears to 0 on the next accepted command.
- entry_write and entry_select are never both nonzero, and never have more than one bit set.
- Latency, with the command accepted at edge T:
  - GET hit: resp_valid at T+3.
  - PUT: resp_valid at T+3.
  - Miss, FULL, DEL or BAD_OP: resp_valid at T+2.
- Throughput is one command per response. With resp_ready held high, the next op_ready follows one cycle after the response handshake.
- Duplicate keys cannot arise, because PUT on a hit overwrites in place.
- occupancy saturates logically at NUM_ENTRIES; it never wraps.

Test Plan:
- Reset, then GET key 0x0042 → MISS at T+2, occupancy 0, no strobes asserted.
- PUT 0x0042 = 0xDEADBEEF, then GET 0x0042 → PUT: OK with entry_write = 0x01 for one cycle. GET: OK, entry_select = 0x01 in the READ cycle, resp_value 0xDEADBEEF at T+3.
- Fill all 8 entries with distinct keys, then PUT a new key → FULL, occupancy 8, no write strobe. DEL the key in entry 3, then PUT the new key → entry_write = 0x08, occupancy 8.
- PUT an existing key with 0x12345678 → in-place overwrite at the same index, occupancy unchanged. A subsequent GET returns 0x12345678.
- Hold resp_ready low for 5 cycles → resp_valid, resp_status and resp_value stay stable, and op_ready stays 0 despite op_valid being high.
- Assert rst during the READ cycle → the next cycle has IDLE, resp_valid 0, occupancy 0 and strobes 0. A following GET of a previously stored key returns MISS. op_code 11 returns BAD_OP.
